vector_phosphor: RTL and testbench
==================================

Name: vector_phosphor

Overview:
Downstream display stage for the vector renderer's 256x256 byte framebuffer. It scans the framebuffer in step with video timing, maps each byte through a CPU-writable 16-entry colour palette scaled by the byte's intensity, and drives RGBA for compositing. It writes back a decayed value to each pixel it reads, giving phosphor-style persistence in place of a hard per-frame clear.

Parameters:
FB_ADDR_WIDTH, 16, framebuffer address width; the address is {vcnt[7:0], hcnt[7:0]}.
FB_DIM, 256, visible framebuffer width and height in pixels.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ce_pix  input  1  pixel strobe, one clk wide, at least 4 clk apart
hcnt  input  9  horizontal counter, valid on the ce_pix cycle
vcnt  input  9  vertical counter, valid on the ce_pix cycle
vblank  input  1  vertical blank
cs  input  1  CPU register select
addr  input  7  CPU register address
data_in  input  8  CPU write data
write  input  1  CPU write strobe; qualified by cs
data_out  output  8  CPU read data, registered, 1 clk latency
fb_addr  output  16  framebuffer read/write-back address
fb_rdata  input  8  framebuffer read data, 1 clk after fb_addr
fb_wr  output  1  framebuffer write-back enable
fb_wdata  output  8  framebuffer write-back data
phos_r  output  8  red output
phos_g  output  8  green output
phos_b  output  8  blue output
phos_a  output  1  alpha: pixel lit

Behaviour:
- Pixel byte format: [7:4] colour index, [3:0] intensity. Intensity 0 means an empty pixel.
- CPU map:
  - 0x00-0x3F: palette. addr[5:2] selects the entry; addr[1:0] selects R=0, G=1, B=2. Offset 3 is reserved: reads 0, writes are ignored.
  - 0x40: decay_step[3:0].
  - 0x41: decay_div[3:0].
  - Other addresses read 0.
  - A write takes effect on the next clk.
- Reset values:
  - phos_r, phos_g, phos_b = 0; phos_a = 0.
  - fb_wr = 0; fb_addr = 0; fb_wdata = 0; data_out = 0.
  - State S_IDLE; frame_cnt = 0.
  - Palette entry k = {k*17, k*17, k*17} (grey ramp).
  - decay_step = 1; decay_div = 0.
- Reset mid-operation forces all of the above immediately; fb_wr drops asynchronously.
- Frame counter:
  - frame_cnt increments on each vblank rising edge and wraps to 0 after reaching decay_div.
  - decay_en = (frame_cnt == 0) && (decay_step != 0).
- Pixel FSM:
  - S_IDLE: on ce_pix with hcnt<256 and vcnt<256, set fb_addr <= {vcnt[7:0], hcnt[7:0]} and go to S_ADDR. On ce_pix outside the area, set phos_r, phos_g, phos_b and phos_a to 0 and stay in S_IDLE.
  - S_ADDR: wait for RAM latency; go to S_DATA.
  - S_DATA: capture fb_rdata, then compute:
    - i = byte[3:0]; c = byte[7:4].
    - New intensity ni = decay_en ? max(i - decay_step, 0) : i, saturating with no wrap.
    - fb_wdata = (ni == 0) ? 8'h00 : {c, ni}.
    - fb_wr = 1 for exactly this one cycle.
    - Go to S_OUT.
  - S_OUT: fb_wr = 0.
    - If i == 0: phos_r, phos_g, phos_b = 0 and phos_a = 0.
    - Otherwise each channel = (pal[c].ch * (i+1)) >> 4 using a 13-bit product with the low 8 bits of the shifted result kept, and phos_a = 1.
    - Outputs use the pre-decay intensity i. Return to S_IDLE.
- Latency: outputs update 3 clk after the ce_pix cycle and hold until the next update.
- Palette read in S_OUT uses the current register contents. A CPU write in the same cycle is seen from the next pixel.
- ce_pix arriving while not in S_IDLE is ignored; this is a protocol violation and no wrong write is allowed to result.
- fb_addr holds its value during S_ADDR and S_DATA, so the write-back hits the same location that was read.

Test Plan:
- Reset: assert reset low -> phos_r=phos_g=phos_b=0 and phos_a=0; CPU reads 0x04=0x11, 0x40=0x01, 0x41=0x00.
- Lit pixel: palette 3 = (FF,80,00), fb byte 0x3F at (10,20), strobe at hcnt=10, vcnt=20 -> fb_addr=0x140A; fb_wr pulse with fb_wdata=0x3E; 3 clk after the strobe, phos_r=FF, phos_g=80, phos_b=00, phos_a=1. Same setup with byte 0x37 -> phos_r=7F, phos_g=40.
- Decay to empty: byte 0x31, decay_step=1 -> fb_wdata=0x00. Same setup with decay_step=0 -> fb_wdata=0x31.
- Divider: decay_div=2, byte 0x3F read once per frame -> decays on 1 frame in 3; value is 0x3E after 3 frames and 0x3D after 6.
- Outside area: strobe at hcnt=300 -> no fb_wr; outputs are all 0.
- Reset mid-op: reset low during S_DATA -> fb_wr=0 immediately; palette returns to the grey ramp.

Source files
------------

// File: rtl/vector_phosphor.sv
// vector_phosphor: display stage for a 256x256 byte framebuffer.
// Each pixel strobe inside the visible area reads one framebuffer byte
// ([7:4] colour index, [3:0] intensity), writes back a decayed copy for
// phosphor-style persistence, and drives RGBA scaled by the palette entry.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   ce_pix, hcnt, vcnt  pixel strobe and scan position (valid with ce_pix)
//   vblank              vertical blank, rising edge advances the decay frame counter
//   cs, addr, data_in,  CPU register port; data_out is registered, 1 clk latency
//   write, data_out
//   fb_addr, fb_rdata   framebuffer read (data 1 clk after address)
//   fb_wr, fb_wdata     framebuffer write-back to the same address
//   phos_r/g/b, phos_a  colour outputs and lit flag
module vector_phosphor #(
  parameter int FB_ADDR_WIDTH = 16,
  parameter int FB_DIM        = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_pix,
  input  logic [8:0]               hcnt,
  input  logic [8:0]               vcnt,
  input  logic                     vblank,
  input  logic                     cs,
  input  logic [6:0]               addr,
  input  logic [7:0]               data_in,
  input  logic                     write,
  output logic [7:0]               data_out,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr,
  input  logic [7:0]               fb_rdata,
  output logic                     fb_wr,
  output logic [7:0]               fb_wdata,
  output logic [7:0]               phos_r,
  output logic [7:0]               phos_g,
  output logic [7:0]               phos_b,
  output logic                     phos_a
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  // Channel scaled by (intensity+1)/16; 13-bit product, low 8 bits of the shifted value.
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [3:0] i);
    logic [12:0] prod;
    prod = 13'(ch) * (13'(i) + 13'd1);
    return 8'(prod >> 4);
  endfunction

  // Saturating intensity decay; a pixel that reaches zero is fully cleared.
  function automatic logic [7:0] decay_byte(input logic [7:0] b, input logic en,
                                            input logic [3:0] step);
    logic [3:0] ni;
    if (!en) begin
      ni = b[3:0];
    end else if (b[3:0] > step) begin
      ni = b[3:0] - step;
    end else begin
      ni = 4'd0;
    end
    return (ni == 4'd0) ? 8'h00 : {b[7:4], ni};
  endfunction

  logic [7:0] pal_r_q [16];
  logic [7:0] pal_g_q [16];
  logic [7:0] pal_b_q [16];
  logic [3:0] decay_step_q, decay_div_q, frame_cnt_q;
  logic       vblank_q;
  logic [7:0] data_out_q, data_out_d, rd_data_s;
  logic       pal_we_s, decay_en_s, in_area_s;

  state_e                   state_q, state_d;
  logic [FB_ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                     fb_wr_q, fb_wr_d, phos_a_q, phos_a_d;
  logic [7:0]               fb_wdata_q, fb_wdata_d, pix_q, pix_d;
  logic [7:0]               phos_r_q, phos_r_d, phos_g_q, phos_g_d, phos_b_q, phos_b_d;

  // Offset 3 of each palette entry is reserved and never stored.
  assign pal_we_s   = cs && write && !addr[6] && (addr[1:0] != 2'd3);
  assign decay_en_s = (frame_cnt_q == 4'd0) && (decay_step_q != 4'd0);
  assign in_area_s  = (hcnt < 9'(FB_DIM)) && (vcnt < 9'(FB_DIM));
  assign data_out_d = (cs && !write) ? rd_data_s : data_out_q;

  // CPU read decode.
  always_comb begin
    rd_data_s = 8'h00;
    if (!addr[6]) begin
      case (addr[1:0])
        2'd0:    rd_data_s = pal_r_q[addr[5:2]];
        2'd1:    rd_data_s = pal_g_q[addr[5:2]];
        2'd2:    rd_data_s = pal_b_q[addr[5:2]];
        default: rd_data_s = 8'h00;
      endcase
    end else if (addr == 7'h40) begin
      rd_data_s = {4'h0, decay_step_q};
    end else if (addr == 7'h41) begin
      rd_data_s = {4'h0, decay_div_q};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // CPU-visible registers: palette, decay controls, read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) begin
        pal_r_q[k] <= 8'(k * 17);
        pal_g_q[k] <= 8'(k * 17);
        pal_b_q[k] <= 8'(k * 17);
      end
      decay_step_q <= 4'd1;
      decay_div_q  <= 4'd0;
      data_out_q   <= 8'h00;
    end else begin
      data_out_q <= data_out_d;
      if (pal_we_s) begin
        case (addr[1:0])
          2'd0:    pal_r_q[addr[5:2]] <= data_in;
          2'd1:    pal_g_q[addr[5:2]] <= data_in;
          default: pal_b_q[addr[5:2]] <= data_in;
        endcase
      end
      if (cs && write && (addr == 7'h40)) decay_step_q <= data_in[3:0];
      if (cs && write && (addr == 7'h41)) decay_div_q  <= data_in[3:0];
    end
  end

  // Frame counter: decay is applied only on frames where it reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_q    <= 1'b0;
      frame_cnt_q <= 4'd0;
    end else begin
      vblank_q <= vblank;
      if (vblank && !vblank_q) begin
        // >= also recovers if decay_div is lowered below the running count.
        frame_cnt_q <= (frame_cnt_q >= decay_div_q) ? 4'd0 : frame_cnt_q + 4'd1;
      end
    end
  end

  // Pixel FSM next-state and output logic.
  always_comb begin
    state_d    = state_q;
    fb_addr_d  = fb_addr_q;
    fb_wr_d    = 1'b0;
    fb_wdata_d = fb_wdata_q;
    pix_d      = pix_q;
    phos_r_d   = phos_r_q;
    phos_g_d   = phos_g_q;
    phos_b_d   = phos_b_q;
    phos_a_d   = phos_a_q;
    case (state_q)
      S_IDLE: begin
        if (ce_pix && in_area_s) begin
          fb_addr_d = FB_ADDR_WIDTH'({vcnt[7:0], hcnt[7:0]});
          state_d   = S_ADDR;
        end else if (ce_pix) begin
          phos_r_d = 8'h00;
          phos_g_d = 8'h00;
          phos_b_d = 8'h00;
          phos_a_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        pix_d      = fb_rdata;
        fb_wdata_d = decay_byte(fb_rdata, decay_en_s, decay_step_q);
        fb_wr_d    = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        // Display uses the intensity as read, before decay.
        if (pix_q[3:0] == 4'd0) begin
          phos_r_d = 8'h00;
          phos_g_d = 8'h00;
          phos_b_d = 8'h00;
          phos_a_d = 1'b0;
        end else begin
          phos_r_d = scale_ch(pal_r_q[pix_q[7:4]], pix_q[3:0]);
          phos_g_d = scale_ch(pal_g_q[pix_q[7:4]], pix_q[3:0]);
          phos_b_d = scale_ch(pal_b_q[pix_q[7:4]], pix_q[3:0]);
          phos_a_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fb_addr_q  <= '0;
      fb_wr_q    <= 1'b0;
      fb_wdata_q <= 8'h00;
      pix_q      <= 8'h00;
      phos_r_q   <= 8'h00;
      phos_g_q   <= 8'h00;
      phos_b_q   <= 8'h00;
      phos_a_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fb_addr_q  <= fb_addr_d;
      fb_wr_q    <= fb_wr_d;
      fb_wdata_q <= fb_wdata_d;
      pix_q      <= pix_d;
      phos_r_q   <= phos_r_d;
      phos_g_q   <= phos_g_d;
      phos_b_q   <= phos_b_d;
      phos_a_q   <= phos_a_d;
    end
  end

  assign data_out = data_out_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wr    = fb_wr_q;
  assign fb_wdata = fb_wdata_q;
  assign phos_r   = phos_r_q;
  assign phos_g   = phos_g_q;
  assign phos_b   = phos_b_q;
  assign phos_a   = phos_a_q;

endmodule

// File: tb/tb_vector_phosphor.sv
// Self-checking bench for vector_phosphor: directed cases plus a randomized
// pass against a behavioural model of palette, decay and frame counting.
module tb_vector_phosphor;

  logic        clk = 1'b0, reset = 1'b0, ce_pix = 1'b0, vblank = 1'b0;
  logic [8:0]  hcnt = 9'd0, vcnt = 9'd0;
  logic        cs = 1'b0, write = 1'b0;
  logic [6:0]  addr = 7'd0;
  logic [7:0]  data_in = 8'd0, data_out, fb_rdata, fb_wdata;
  logic [15:0] fb_addr;
  logic        fb_wr, phos_a;
  logic [7:0]  phos_r, phos_g, phos_b;

  vector_phosphor dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
    .vblank(vblank), .cs(cs), .addr(addr), .data_in(data_in), .write(write),
    .data_out(data_out), .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_wr(fb_wr),
    .fb_wdata(fb_wdata), .phos_r(phos_r), .phos_g(phos_g), .phos_b(phos_b),
    .phos_a(phos_a)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM: registered read, write-back port plus a bench preload port.
  logic [7:0]  ram [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_waddr = 16'd0;
  logic [7:0]  tb_wdata = 8'd0;
  int          wr_cnt = 0;
  always @(posedge clk) begin
    fb_rdata <= ram[fb_addr];
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (fb_wr) ram[fb_addr] <= fb_wdata;
    if (fb_wr) wr_cnt <= wr_cnt + 1;
  end

  int n_assert = 0, n_fail = 0;
  int m_r [16], m_g [16], m_b [16];
  int m_step, m_div, m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_r[k] = k * 17; m_g[k] = k * 17; m_b[k] = k * 17;
    end
    m_step = 1; m_div = 0; m_fc = 0;
  endtask

  task automatic cpu_wr(input int a, input int d);
    @(negedge clk); cs = 1'b1; write = 1'b1; addr = 7'(a); data_in = 8'(d);
    @(negedge clk); cs = 1'b0; write = 1'b0;
    if (a < 64) begin
      if (a % 4 == 0) m_r[a / 4] = d;
      else if (a % 4 == 1) m_g[a / 4] = d;
      else if (a % 4 == 2) m_b[a / 4] = d;
    end else if (a == 64) m_step = d % 16;
    else if (a == 65) m_div = d % 16;
  endtask

  task automatic cpu_rd(input string tag, input int a, input int exp);
    @(negedge clk); cs = 1'b1; write = 1'b0; addr = 7'(a);
    @(negedge clk); cs = 1'b0;
    chk(tag, 32'(data_out), 32'(exp));
  endtask

  task automatic vblank_pulse();
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    m_fc = (m_fc + 1) % (m_div + 1);
  endtask

  task automatic preload(input int a, input int b);
    @(negedge clk); tb_we = 1'b1; tb_waddr = 16'(a); tb_wdata = 8'(b);
    @(negedge clk); tb_we = 1'b0;
  endtask

  // One in-area pixel; glitch re-strobes during the wait state (must be ignored).
  task automatic do_pixel(input string tag, input int h, input int v, input int b,
                          input bit glitch, output int exp_w);
    int i, c, ni, a, base, er, eg, eb, ea;
    a = v * 256 + h;
    preload(a, b);
    i = b % 16; c = b / 16;
    ni = i;
    if (m_fc == 0 && m_step != 0) ni = (i > m_step) ? i - m_step : 0;
    exp_w = (ni == 0) ? 0 : c * 16 + ni;
    if (i == 0) begin er = 0; eg = 0; eb = 0; ea = 0; end
    else begin
      er = (m_r[c] * (i + 1) / 16) % 256;
      eg = (m_g[c] * (i + 1) / 16) % 256;
      eb = (m_b[c] * (i + 1) / 16) % 256;
      ea = 1;
    end
    base = wr_cnt;
    @(negedge clk); ce_pix = 1'b1; hcnt = 9'(h); vcnt = 9'(v);
    @(negedge clk);
    if (glitch) begin hcnt = 9'((h + 1) % 256); vcnt = 9'((v + 3) % 256); end
    else ce_pix = 1'b0;
    @(negedge clk); ce_pix = 1'b0;
    @(negedge clk);
    chk({tag, ".fb_wr"}, 32'(fb_wr), 32'd1);
    chk({tag, ".fb_wdata"}, 32'(fb_wdata), 32'(exp_w));
    chk({tag, ".fb_addr"}, 32'(fb_addr), 32'(a));
    @(negedge clk);
    chk({tag, ".phos_r"}, 32'(phos_r), 32'(er));
    chk({tag, ".phos_g"}, 32'(phos_g), 32'(eg));
    chk({tag, ".phos_b"}, 32'(phos_b), 32'(eb));
    chk({tag, ".phos_a"}, 32'(phos_a), 32'(ea));
    chk({tag, ".wr_pulses"}, 32'(wr_cnt - base), 32'd1);
    chk({tag, ".ram"}, 32'(ram[a]), 32'(exp_w));
  endtask

  initial begin
    int w, base, mv, h, v;
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.phos_r", 32'(phos_r), 32'd0);
    chk("rst.phos_a", 32'(phos_a), 32'd0);
    chk("rst.fb_wr", 32'(fb_wr), 32'd0);
    chk("rst.fb_addr", 32'(fb_addr), 32'd0);
    chk("rst.fb_wdata", 32'(fb_wdata), 32'd0);
    chk("rst.data_out", 32'(data_out), 32'd0);
    reset = 1'b1;
    cpu_rd("rd.pal1r", 7'h04, 8'h11);
    cpu_rd("rd.step", 7'h40, 8'h01);
    cpu_rd("rd.div", 7'h41, 8'h00);
    cpu_rd("rd.pal15b", 7'h3E, 8'hFF);
    cpu_rd("rd.other", 7'h55, 8'h00);

    // Palette 3 = (FF,80,00); reserved offset ignored
    cpu_wr(7'h0C, 8'hFF); cpu_wr(7'h0D, 8'h80); cpu_wr(7'h0E, 8'h00);
    cpu_wr(7'h0F, 8'hAA);
    cpu_rd("rd.reserved", 7'h0F, 8'h00);
    cpu_rd("rd.pal3g", 7'h0D, 8'h80);

    // Lit pixels at (10,20)
    do_pixel("lit3F", 10, 20, 8'h3F, 1'b0, w);
    chk("lit3F.addr", 32'(fb_addr), 32'h140A);
    chk("lit3F.r", 32'(phos_r), 32'hFF);
    do_pixel("lit37", 10, 20, 8'h37, 1'b0, w);
    chk("lit37.r", 32'(phos_r), 32'h7F);
    chk("lit37.g", 32'(phos_g), 32'h40);

    // Decay to empty, and no decay with step 0
    do_pixel("dec31", 10, 20, 8'h31, 1'b0, w);
    chk("dec31.w", 32'(w), 32'h00);
    cpu_wr(7'h40, 8'h00);
    do_pixel("nodec31", 10, 20, 8'h31, 1'b0, w);
    chk("nodec31.w", 32'(w), 32'h31);
    do_pixel("empty", 40, 50, 8'h50, 1'b0, w);

    // Outside area
    do_pixel("relit", 1, 2, 8'h3F, 1'b0, w);
    base = wr_cnt;
    @(negedge clk); ce_pix = 1'b1; hcnt = 9'd300; vcnt = 9'd20;
    @(negedge clk); ce_pix = 1'b0;
    repeat (3) @(negedge clk);
    chk("out.wr_pulses", 32'(wr_cnt - base), 32'd0);
    chk("out.phos_r", 32'(phos_r), 32'd0);
    chk("out.phos_g", 32'(phos_g), 32'd0);
    chk("out.phos_a", 32'(phos_a), 32'd0);
    @(negedge clk); ce_pix = 1'b1; hcnt = 9'd10; vcnt = 9'd256;
    @(negedge clk); ce_pix = 1'b0;
    repeat (3) @(negedge clk);
    chk("outv.wr_pulses", 32'(wr_cnt - base), 32'd0);

    // Strobe during wait state is ignored
    do_pixel("glitch", 5, 6, 8'h9A, 1'b1, w);

    // Divider: decay on 1 frame in 3
    cpu_wr(7'h40, 8'h01); cpu_wr(7'h41, 8'h02);
    mv = 8'h3F;
    for (int f = 1; f <= 6; f++) begin
      do_pixel("div", 100, 200, mv, 1'b0, w);
      mv = w;
      vblank_pulse();
      if (f == 3) chk("div.f3", 32'(ram[16'hC864]), 32'h3E);
    end
    chk("div.f6", 32'(ram[16'hC864]), 32'h3D);

    // Reset during S_DATA
    preload(16'h0303, 8'hFF);
    base = wr_cnt;
    @(negedge clk); ce_pix = 1'b1; hcnt = 9'd3; vcnt = 9'd3;
    @(negedge clk); ce_pix = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1 chk("rstdata.fb_wr", 32'(fb_wr), 32'd0);
    chk("rstdata.phos_a", 32'(phos_a), 32'd0);
    @(negedge clk); reset = 1'b1; model_reset();
    repeat (3) @(negedge clk);
    chk("rstdata.wr_pulses", 32'(wr_cnt - base), 32'd0);
    cpu_rd("rstdata.pal3r", 7'h0C, 8'h33);

    // Reset while the write-back pulse is high
    base = wr_cnt;
    @(negedge clk); ce_pix = 1'b1; hcnt = 9'd3; vcnt = 9'd3;
    @(negedge clk); ce_pix = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstout.fb_wr_hi", 32'(fb_wr), 32'd1);
    reset = 1'b0;
    #1 chk("rstout.fb_wr", 32'(fb_wr), 32'd0);
    @(negedge clk); reset = 1'b1; model_reset();
    chk("rstout.wr_pulses", 32'(wr_cnt - base), 32'd0);
    chk("rstout.ram", 32'(ram[16'h0303]), 32'hFF);

    // Randomized pixels against the model
    cpu_wr(7'h41, $urandom_range(3, 0));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) cpu_wr($urandom_range(63, 0), $urandom_range(255, 0));
      if (n % 10 == 0) cpu_wr(7'h40, $urandom_range(3, 0));
      h = $urandom_range(255, 0); v = $urandom_range(255, 0);
      do_pixel("rnd", h, v, $urandom_range(255, 0), 1'b0, w);
      if (n % 3 == 2) vblank_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
